// File: rtl/sort4_controller_pkg.sv
// Shared definitions for the sort4 controller: data width and FSM state encoding.
package sort4_controller_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SORT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sort4_controller_comparator.sv
// Combinational unsigned magnitude comparator shared by the sort sequencer.
module comparator
  import sort4_controller_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         x_gt_y,
  output logic         x_eq_y,
  output logic         x_lt_y
);

  assign x_gt_y = (x > y);
  assign x_eq_y = (x == y);
  assign x_lt_y = (x < y);

endmodule

// File: rtl/sort4_controller.sv
// Serial load, in-place bubble sort (one compare-and-swap per cycle) and ascending drain
// of DEPTH unsigned words around a single shared comparator.
module sort4_controller
  import sort4_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic         done
);

  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] ZERO      = {IW{1'b0}};
  localparam logic [IW-1:0] ONE       = IW'(1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

  state_t        state_r, state_next;
  logic [IW-1:0] li_r, li_next, j_r, j_next, k_r, k_next, pass_r, pass_next;
  logic          swapped_r, swapped_next, swap_any;
  logic [W-1:0]  mem_r    [DEPTH];
  logic [W-1:0]  mem_next [DEPTH];
  logic          busy_r, out_valid_r, done_r;
  logic [W-1:0]  dout_r;

  logic [W-1:0]  cmp_x, cmp_y;
  logic          x_gt_y, x_eq_y, x_lt_y;
  logic          unused_cmp;

  assign cmp_x = mem_r[j_r];
  assign cmp_y = mem_r[j_r + ONE];

  comparator u_cmp (
    .x      (cmp_x),
    .y      (cmp_y),
    .x_gt_y (x_gt_y),
    .x_eq_y (x_eq_y),
    .x_lt_y (x_lt_y)
  );

  // Only a strict greater-than swaps, which keeps equal keys in their load order.
  assign unused_cmp = x_eq_y ^ x_lt_y;

  // Next-state, counter and register-bank update logic.
  always_comb begin
    state_next   = state_r;
    li_next      = li_r;
    j_next       = j_r;
    k_next       = k_r;
    pass_next    = pass_r;
    swapped_next = swapped_r;
    swap_any     = swapped_r | x_gt_y;
    mem_next     = mem_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          li_next    = ZERO;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mem_next[li_r] = din;
          if (li_r == LAST_IDX) begin
            state_next   = S_SORT;
            j_next       = ZERO;
            pass_next    = ZERO;
            swapped_next = 1'b0;
          end else begin
            li_next = li_r + ONE;
          end
        end else begin
          li_next = li_r;
        end
      end
      S_SORT: begin
        if (x_gt_y) begin
          mem_next[j_r]       = cmp_y;
          mem_next[j_r + ONE] = cmp_x;
        end else begin
          mem_next[j_r] = cmp_x;
        end
        // Pass p ends at j = DEPTH-2-p; a pass without swaps means the bank is sorted.
        if (j_r == (LAST_PASS - pass_r)) begin
          if (swap_any && (pass_r < LAST_PASS)) begin
            j_next       = ZERO;
            pass_next    = pass_r + ONE;
            swapped_next = 1'b0;
          end else begin
            state_next   = S_DRAIN;
            k_next       = ZERO;
            swapped_next = swap_any;
          end
        end else begin
          j_next       = j_r + ONE;
          swapped_next = swap_any;
        end
      end
      S_DRAIN: begin
        if (k_r == LAST_IDX) begin
          state_next = S_IDLE;
          k_next     = ZERO;
        end else begin
          k_next = k_r + ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, bank and output registers; outputs are loaded from next-state values so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      li_r        <= ZERO;
      j_r         <= ZERO;
      k_r         <= ZERO;
      pass_r      <= ZERO;
      swapped_r   <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      dout_r      <= {W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      state_r     <= state_next;
      li_r        <= li_next;
      j_r         <= j_next;
      k_r         <= k_next;
      pass_r      <= pass_next;
      swapped_r   <= swapped_next;
      busy_r      <= (state_next != S_IDLE);
      out_valid_r <= (state_next == S_DRAIN);
      done_r      <= (state_next == S_DRAIN) && (k_next == LAST_IDX);
      dout_r      <= (state_next == S_DRAIN) ? mem_next[k_next] : {W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_next[i];
      end
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign dout      = dout_r;
  assign done      = done_r;

endmodule
